fp_norm_round: RTL and testbench
================================

Name: fp_norm_round

Overview:
Final stage of the real multiplier. It consumes the biased exponent sum (op1.exp + op2.exp - BIAS) from the exponent adder, the result sign and the raw significand product. It normalizes the product, handles denormal outputs with a bit-serial right shift, rounds to nearest-even, and packs the IEEE-754 result. A multi-cycle FSM with valid/ready handshakes on both sides.

Parameters:
IS_DOUBLE, 0, 1 selects binary64, 0 selects binary32
WIDTH, IS_DOUBLE ? 64 : 32, packed result width
EXPONENT_W, IS_DOUBLE ? 11 : 8, exponent field width
MANTISSA_W, IS_DOUBLE ? 52 : 23, stored mantissa width (PW = 2*(MANTISSA_W+1) is the product width)

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream operand bundle valid
in_ready  output  1  high exactly in IDLE
in_sign  input  1  result sign (op1.sign ^ op2.sign)
in_exp  input  EXPONENT_W+2  signed biased exponent sum, range [-BIAS, 2*(2^EXPONENT_W-2)-BIAS]
in_prod  input  PW  unsigned significand product, 2 integer bits (bit PW-2 = weight 1)
in_zero  input  1  an operand is zero; result is signed zero
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  downstream accept
res  output  WIDTH  packed result
overflow  output  1  result rounded to infinity
underflow  output  1  result tiny (exp field 0 before rounding) and inexact
inexact  output  1  rounding discarded nonzero bits, or overflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, res=0, all flags 0, internal regs 0. Reset mid-operation abandons the bundle; nothing is emitted.
- Internal regs: P (PW bits), E (signed, EXPONENT_W+3 bits), S (sticky), sign, zero.
- IDLE: in_ready=1. When in_valid, load P=in_prod, E=sign-extended in_exp, S=0 -> ALIGN. If in_zero, go directly to DONE with res={in_sign,0...}, flags 0.
- ALIGN: one action per cycle, evaluated in priority order:
  (a) P[PW-1]=1: P>>=1, S|=dropped bit, E+=1.
  (b) E < -(MANTISSA_W+2): S|=|P, P=0, E=1 (shortcut; bounds the cycle count).
  (c) E<1: P>>=1, S|=dropped bit, E+=1.
  (d) P[PW-2]=0 and P!=0 and E>1: P<<=1, E-=1 (denormal-operand renormalization).
  (e) otherwise -> ROUND.
- ROUND, one cycle:
  - If E >= 2^EXPONENT_W-1: res=±inf, overflow=1, inexact=1.
  - Otherwise:
    - ef = P[PW-2] ? E : 0
    - mant = P[PW-3 -: MANTISSA_W]
    - G = next bit below mant
    - St = OR(remaining lower bits) | S
    - up = G & (St | mant[0])
    - {exp_field, mant_field} = {ef, mant} + up; the carry propagates into the exponent, covering mantissa overflow and denormal->min-normal.
    - If the resulting exp_field is all ones: overflow=1 (inf).
    - inexact = G|St; underflow = (ef==0) & inexact.
  - -> DONE.
- DONE: out_valid=1. res and flags stay stable while out_ready=0. On out_ready: out_valid=0 -> IDLE. A new bundle cannot be accepted in the same cycle.
- Latency: accept at edge T.
  - No shift: out_valid is high after edge T+3.
  - Each ALIGN shift adds 1 cycle; worst case is about MANTISSA_W+4 shifts.
  - Zero path: out_valid after T+1.
- in_prod=0 without in_zero: treated as zero magnitude, res=±0.

Decomposition:
- Shared package fp_mult_pkg: format localparams (WIDTH/EXPONENT_W/MANTISSA_W/BIAS/PW keyed by IS_DOUBLE), FSM state enum {IDLE, ALIGN, ROUND, DONE}, and the inf/zero packing constants. The exponent adder reuses the same package.
- One sub-module: fp_rne_rounder, combinational. Takes ef, mant, G and St; returns the packed field, overflow and inexact.

Test Plan:
- Binary32, in_exp=127, in_prod=0x900000000000 (1.5*1.5) -> res=0x40100000, inexact=0, out_valid after edge T+4 (one (a) shift).
- in_exp=127, in_prod=0x400000400000 (tie, lsb 0) -> res=0x3F800000, inexact=1. Then in_prod=0x400000C00000 -> res=0x3F800002.
- in_exp=254, in_prod=0x800000000000 -> res=0x7F800000, overflow=1, inexact=1.
- in_exp=-1, in_prod=0x400000000000 -> res=0x00200000, underflow=0, inexact=0 (two (c) shifts). Then in_exp=-200 -> shortcut, res=0x00000000, underflow=1, inexact=1.
- in_zero=1, in_sign=1 -> res=0x80000000, flags 0, out_valid after edge T+1.
- Hold out_ready=0 for 5 cycles in DONE -> res/flags stable, in_ready=0. Then drop rst_n during ALIGN -> out_valid=0, res=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/fp_mult_pkg.sv
// Shared format constants and FSM encoding for the real multiplier datapath.
// The exponent adder and the normalize/round stage both key their widths off IS_DOUBLE here.
package fp_mult_pkg;

  function automatic int fmt_width(input bit is_double);
    return is_double ? 64 : 32;
  endfunction

  function automatic int fmt_exp_w(input bit is_double);
    return is_double ? 11 : 8;
  endfunction

  function automatic int fmt_mant_w(input bit is_double);
    return is_double ? 52 : 23;
  endfunction

  function automatic int fmt_bias(input bit is_double);
    return is_double ? 1023 : 127;
  endfunction

  // Product of two significands with hidden bits: two integer bits above the fraction.
  function automatic int fmt_pw(input bit is_double);
    return 2 * (fmt_mant_w(is_double) + 1);
  endfunction

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ALIGN = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Magnitude (everything below the sign) of infinity, zero-extended to the binary64 size.
  localparam logic [62:0] SP_INF_MAG = {32'd0, 8'hFF, 23'd0};
  localparam logic [62:0] DP_INF_MAG = {11'h7FF, 52'd0};
  localparam logic [62:0] ZERO_MAG   = 63'd0;

endpackage

// File: rtl/fp_norm_round_if.sv
// Operand bundle in, packed result out, each side with its own valid/ready pair.
interface fp_norm_round_if #(
  parameter bit IS_DOUBLE = 1'b0
) ();
  import fp_mult_pkg::*;

  localparam int WIDTH = fmt_width(IS_DOUBLE);
  localparam int EW    = fmt_exp_w(IS_DOUBLE);
  localparam int PW    = fmt_pw(IS_DOUBLE);

  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EW+1:0]    in_exp;
  logic [PW-1:0]    in_prod;
  logic             in_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             overflow;
  logic             underflow;
  logic             inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_prod, in_zero, out_ready,
    input  in_ready, out_valid, res, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_prod, in_zero, out_ready,
    output in_ready, out_valid, res, overflow, underflow, inexact
  );

endinterface

// File: rtl/fp_rne_rounder.sv
// Round-to-nearest-even on an {exponent, mantissa} field pair.
// The increment carries straight into the exponent, so mantissa overflow needs no special case.
module fp_rne_rounder #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [EW-1:0]    ef_i,
  input  logic [MW-1:0]    mant_i,
  input  logic             g_i,
  input  logic             st_i,
  output logic [EW+MW-1:0] field_o,
  output logic             overflow_o,
  output logic             inexact_o
);

  logic up;

  assign up         = g_i & (st_i | mant_i[0]);
  assign field_o    = {ef_i, mant_i} + {{(EW+MW-1){1'b0}}, up};
  assign overflow_o = &field_o[EW+MW-1 -: EW];
  assign inexact_o  = g_i | st_i;

endmodule

// File: rtl/fp_norm_round.sv
// Normalize, denormalize and round the raw significand product, then pack the IEEE-754 result.
// One shift per cycle in ALIGN; out_valid rises one cycle after the FSM reaches DONE.
module fp_norm_round #(
  parameter bit IS_DOUBLE = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  fp_norm_round_if.slave bus
);
  import fp_mult_pkg::*;

  localparam int WIDTH = fmt_width(IS_DOUBLE);
  localparam int EW    = fmt_exp_w(IS_DOUBLE);
  localparam int MW    = fmt_mant_w(IS_DOUBLE);
  localparam int PW    = fmt_pw(IS_DOUBLE);
  localparam int XW    = EW + 3;

  localparam logic signed [XW-1:0] E_ONE   = XW'(1);
  localparam logic signed [XW-1:0] E_SHORT = XW'(-(MW + 2));
  localparam logic signed [XW-1:0] E_MAX   = XW'((1 << EW) - 1);

  localparam logic [62:0]      INF_WIDE  = IS_DOUBLE ? DP_INF_MAG : SP_INF_MAG;
  localparam logic [WIDTH-2:0] INF_MAG   = INF_WIDE[WIDTH-2:0];
  localparam logic [WIDTH-2:0] ZERO_FLD  = ZERO_MAG[WIDTH-2:0];

  state_t               state_q, state_d;
  logic [PW-1:0]        p_q, p_d;
  logic signed [XW-1:0] e_q, e_d;
  logic                 s_q, s_d;
  logic                 sign_q, sign_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 inx_q, inx_d;
  logic                 out_valid_q, out_valid_d;

  logic [EW-1:0]        ef;
  logic [MW-1:0]        mant;
  logic                 g_bit;
  logic                 st_bit;
  logic [EW+MW-1:0]     rnd_field;
  logic                 rnd_ovf;
  logic                 rnd_inx;

  // A product without its weight-1 bit set has reached the denormal range: exponent field 0.
  assign ef     = p_q[PW-2] ? e_q[EW-1:0] : '0;
  assign mant   = p_q[PW-3 -: MW];
  assign g_bit  = p_q[PW-3-MW];
  assign st_bit = (|p_q[PW-4-MW:0]) | s_q;

  fp_rne_rounder #(
    .EW (EW),
    .MW (MW)
  ) u_rounder (
    .ef_i       (ef),
    .mant_i     (mant),
    .g_i        (g_bit),
    .st_i       (st_bit),
    .field_o    (rnd_field),
    .overflow_o (rnd_ovf),
    .inexact_o  (rnd_inx)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    e_d         = e_q;
    s_d         = s_q;
    sign_d      = sign_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_zero || (bus.in_prod == '0)) begin
            res_d   = {bus.in_sign, ZERO_FLD};
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            inx_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            p_d     = bus.in_prod;
            e_d     = {bus.in_exp[EW+1], bus.in_exp};
            s_d     = 1'b0;
            sign_d  = bus.in_sign;
            state_d = ST_ALIGN;
          end
        end
      end

      ST_ALIGN: begin
        if (p_q[PW-1]) begin
          p_d = p_q >> 1;
          s_d = s_q | p_q[0];
          e_d = e_q + E_ONE;
        end else if (e_q < E_SHORT) begin
          // Far below the denormal range every bit would be shifted out anyway.
          s_d = s_q | (|p_q);
          p_d = '0;
          e_d = E_ONE;
        end else if (e_q < E_ONE) begin
          p_d = p_q >> 1;
          s_d = s_q | p_q[0];
          e_d = e_q + E_ONE;
        end else if (!p_q[PW-2] && (p_q != '0) && (e_q > E_ONE)) begin
          p_d = p_q << 1;
          e_d = e_q - E_ONE;
        end else begin
          state_d = ST_ROUND;
        end
      end

      ST_ROUND: begin
        if (e_q >= E_MAX) begin
          res_d = {sign_q, INF_MAG};
          ovf_d = 1'b1;
          unf_d = 1'b0;
          inx_d = 1'b1;
        end else begin
          res_d = {sign_q, rnd_field};
          ovf_d = rnd_ovf;
          unf_d = (ef == '0) & rnd_inx;
          inx_d = rnd_inx;
        end
        state_d = ST_DONE;
      end

      default: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      sign_q      <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      e_q         <= e_d;
      s_q         <= s_d;
      sign_q      <= sign_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.inexact   = inx_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed binary32 vectors for fp_norm_round with hand-computed results and latencies.
module tb_fp_norm_round;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fp_norm_round_if #(.IS_DOUBLE(1'b0)) bus ();

  fp_norm_round #(.IS_DOUBLE(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one bundle, wait for out_valid, check latency/result/flags; result is left pending.
  task automatic send(input string tag, input logic sign, input int ex, input logic [47:0] prod,
                      input logic zero, input logic [31:0] exp_res, input logic exp_ovf,
                      input logic exp_unf, input logic exp_inx, input int exp_lat,
                      output int lat);
    @(negedge clk);
    check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_sign  = sign;
    bus.in_exp   = ex[9:0];
    bus.in_prod  = prod;
    bus.in_zero  = zero;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 999;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_res"}, 64'(bus.res), 64'(exp_res));
    check_eq({tag, "_flags"}, 64'({bus.overflow, bus.underflow, bus.inexact}),
             64'({exp_ovf, exp_unf, exp_inx}));
    $display("[TB] %s: res=%08h ovf=%0b unf=%0b inx=%0b lat=%0d", tag, bus.res,
             bus.overflow, bus.underflow, bus.inexact, lat);
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_drained"}, 64'({bus.out_valid, bus.in_ready}), 64'({1'b0, 1'b1}));
  endtask

  task automatic xact(input string tag, input logic sign, input int ex, input logic [47:0] prod,
                      input logic zero, input logic [31:0] exp_res, input logic exp_ovf,
                      input logic exp_unf, input logic exp_inx, input int exp_lat);
    int lat;
    send(tag, sign, ex, prod, zero, exp_res, exp_ovf, exp_unf, exp_inx, exp_lat, lat);
    if (lat != 999) release_result(tag);
  endtask

  initial begin
    int lat;
    int seen_valid;
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_prod   = '0;
    bus.in_zero   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_state", 64'({bus.out_valid, bus.in_ready, bus.overflow, bus.underflow,
             bus.inexact}), 64'({1'b0, 1'b1, 3'b000}));
    check_eq("rst_res", 64'(bus.res), 64'd0);

    //        tag          sign  exp   product            zero  result        ovf  unf  inx  lat
    xact("mul_1p5",        1'b0, 127,  48'h900000000000, 1'b0, 32'h40100000, 1'b0, 1'b0, 1'b0, 4);
    xact("mul_1p5_neg",    1'b1, 127,  48'h900000000000, 1'b0, 32'hC0100000, 1'b0, 1'b0, 1'b0, 4);
    xact("tie_even",       1'b0, 127,  48'h400000400000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1, 3);
    xact("tie_odd_up",     1'b0, 127,  48'h400000C00000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1, 3);
    xact("mant_carry",     1'b0, 127,  48'h7FFFFFC00000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1, 3);
    xact("ovf_inf",        1'b0, 254,  48'h800000000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1, 4);
    xact("denorm_exact",   1'b0, -1,   48'h400000000000, 1'b0, 32'h00200000, 1'b0, 1'b0, 1'b0, 5);
    xact("denorm_to_min",  1'b0, 0,    48'h7FFFFFC00000, 1'b0, 32'h00800000, 1'b0, 1'b1, 1'b1, 4);
    xact("shortcut",       1'b0, -200, 48'h400000000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 4);
    xact("renorm",         1'b0, 130,  48'h100000000000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 5);
    xact("zero_op",        1'b1, 127,  48'h900000000000, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0, 1);
    xact("zero_prod",      1'b1, 127,  48'h000000000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1);

    // Hold the result pending and confirm it stays put while downstream stalls.
    send("hold", 1'b0, 127, 48'h900000000000, 1'b0, 32'h40100000, 1'b0, 1'b0, 1'b0, 4, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_eq("hold_res", 64'(bus.res), 64'h40100000);
      check_eq("hold_ctl", 64'({bus.out_valid, bus.in_ready, bus.overflow, bus.underflow,
               bus.inexact}), 64'({1'b1, 1'b0, 3'b000}));
    end
    release_result("hold");

    // Abandon a bundle mid-ALIGN with an asynchronous reset.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_exp   = 10'h3FF;
    bus.in_prod  = 48'h400000000000;
    bus.in_zero  = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out", 64'({bus.out_valid, bus.overflow, bus.underflow, bus.inexact}), 64'd0);
    check_eq("arst_res", 64'(bus.res), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("arst_ready", 64'(bus.in_ready), 64'd1);
    seen_valid = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_valid = 1;
    end
    check_eq("arst_no_emit", 64'(seen_valid), 64'd0);
    $display("[TB] arst: bundle dropped, out_valid seen=%0d", seen_valid);

    xact("after_rst",      1'b0, 127,  48'h400000C00000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
